// File: rtl/scan_pkg.sv
// Shared definitions for the seven-segment scan path: default widths, digit type
// and the active-low one-hot anode helper.
package scan_pkg;

   localparam int unsigned N_DIGITS_DEF = 4;
   localparam int unsigned DIGIT_W_DEF  = 4;
   localparam int unsigned MAX_DIGITS   = 32;

   typedef logic [DIGIT_W_DEF-1:0] digit_t;

   // Bit idx low, every other bit high; callers truncate to their digit count.
   function automatic logic [MAX_DIGITS-1:0] onehot_n(input int unsigned idx,
                                                      input int unsigned n);
      logic [MAX_DIGITS-1:0] v;
      v = '1;
      if (idx < n) v[idx[4:0]] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running enable-gated divider: tick is high for the one cycle in every
// PRESCALE enabled cycles where the count sits at PRESCALE-1.
module scan_prescaler #(
   parameter int unsigned PRESCALE = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned    CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner with per-digit blanking and frame sync.
// Optional blinking of masked digits is enabled by defining SCAN_BLINK_EN.
module digit_scan_mux
   import scan_pkg::*;
#(
   parameter int unsigned N_DIGITS     = N_DIGITS_DEF,
   parameter int unsigned DIGIT_W      = DIGIT_W_DEF,
   parameter int unsigned PRESCALE     = 100000,
`ifdef SCAN_BLINK_EN
   parameter int unsigned BLINK_FRAMES = 64,
`endif
   localparam int unsigned IDX_W       = $clog2(N_DIGITS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [N_DIGITS*DIGIT_W-1:0]  digits_in,
   input  logic [N_DIGITS-1:0]          blank_mask,
`ifdef SCAN_BLINK_EN
   input  logic [N_DIGITS-1:0]          blink_mask,
`endif
   output logic [DIGIT_W-1:0]           digit_out,
   output logic [N_DIGITS-1:0]          anode_n,
   output logic [IDX_W-1:0]             digit_idx,
   output logic                         frame_start
);

   logic                tick;
   logic [IDX_W-1:0]    idx;
   logic                last_idx;
   logic [DIGIT_W-1:0]  digit_sel;
   logic                blank_sel;
   logic                blink_off;
   logic [N_DIGITS-1:0] sel_n;
`ifdef SCAN_BLINK_EN
   logic                blink_sel;
`endif

   scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .tick  (tick)
   );

   assign last_idx = (idx == IDX_W'(N_DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (tick) begin
         idx <= last_idx ? '0 : idx + IDX_W'(1);
      end
   end

   always_comb begin
      digit_sel = '0;
      blank_sel = 1'b0;
`ifdef SCAN_BLINK_EN
      blink_sel = 1'b0;
`endif
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            digit_sel = digits_in[k*DIGIT_W +: DIGIT_W];
            blank_sel = blank_mask[k];
`ifdef SCAN_BLINK_EN
            blink_sel = blink_mask[k];
`endif
         end
      end
      sel_n = N_DIGITS'(onehot_n(32'(idx), N_DIGITS));
   end

`ifdef SCAN_BLINK_EN
   localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FCNT_W-1:0] frame_cnt;
   logic              phase_on;

   // Frame wrap is the slot tick out of the last digit; tick already implies en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (tick && last_idx) begin
         if (frame_cnt == FCNT_W'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            phase_on  <= !phase_on;
         end else begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
         end
      end
   end

   assign blink_off = !phase_on && blink_sel;
`else
   assign blink_off = 1'b0;
`endif

   // digit_idx trails idx by one enabled cycle, so idx=0 with digit_idx!=0 only follows a wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_out   <= '0;
         anode_n     <= '1;
         digit_idx   <= '0;
         frame_start <= 1'b0;
      end else if (en) begin
         digit_out   <= digit_sel;
         digit_idx   <= idx;
         anode_n     <= (blank_sel || blink_off) ? '1 : sel_n;
         frame_start <= (idx == '0) && (digit_idx != '0);
      end else begin
         anode_n     <= '1;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomised self-checking bench for digit_scan_mux against a slot-arithmetic model.
// Define SCAN_BLINK_EN to also exercise the blink path.
module tb_digit_scan_mux;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int P  = 3;
   localparam int IW = $clog2(N);
`ifdef SCAN_BLINK_EN
   localparam int BF = 2;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           en;
   logic [N*W-1:0] digits_in;
   logic [N-1:0]   blank_mask;
`ifdef SCAN_BLINK_EN
   logic [N-1:0]   blink_mask;
`endif
   logic [W-1:0]   digit_out;
   logic [N-1:0]   anode_n;
   logic [IW-1:0]  digit_idx;
   logic           frame_start;

   logic           en6;
   logic [23:0]    digits6;
   logic [3:0]     digit_out6;
   logic [5:0]     anode_n6;
   logic [2:0]     digit_idx6;
   logic           frame_start6;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: enabled edges since reset and expected outputs
   int unsigned   ecount, pos6;
   logic [W-1:0]  exp_digit;
   logic [N-1:0]  exp_anode;
   logic [IW-1:0] exp_idx;
   logic          exp_fs;
   logic [3:0]    exp_digit6;
   logic [5:0]    exp_anode6;
   logic [2:0]    exp_idx6;
   logic          exp_fs6;

   always #5 clk = ~clk;

   digit_scan_mux #(
      .N_DIGITS(N), .DIGIT_W(W), .PRESCALE(P)
`ifdef SCAN_BLINK_EN
      , .BLINK_FRAMES(BF)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in), .blank_mask(blank_mask),
`ifdef SCAN_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .digit_out(digit_out), .anode_n(anode_n), .digit_idx(digit_idx), .frame_start(frame_start)
   );

   digit_scan_mux #(
      .N_DIGITS(6), .DIGIT_W(4), .PRESCALE(1)
`ifdef SCAN_BLINK_EN
      , .BLINK_FRAMES(2)
`endif
   ) dut6 (
      .clk(clk), .rst_n(rst_n), .en(en6), .digits_in(digits6), .blank_mask(6'b0),
`ifdef SCAN_BLINK_EN
      .blink_mask(6'b0),
`endif
      .digit_out(digit_out6), .anode_n(anode_n6), .digit_idx(digit_idx6), .frame_start(frame_start6)
   );

   task automatic model_reset();
      ecount = 0; pos6 = 0;
      exp_digit = '0; exp_anode = '1; exp_idx = '0; exp_fs = 1'b0;
      exp_digit6 = '0; exp_anode6 = '1; exp_idx6 = '0; exp_fs6 = 1'b0;
   endtask

   // Advance one clock, update the model from the inputs seen at the edge, sample at +1.
   task automatic tick();
      int unsigned slot, frame;
      logic off;
      @(posedge clk);
      if (rst_n) begin
         if (en) begin
            slot  = (ecount / P) % N;
            frame = ecount / (N * P);
            off   = blank_mask[slot];
`ifdef SCAN_BLINK_EN
            if (((frame / BF) % 2) == 1 && blink_mask[slot]) off = 1'b1;
`endif
            exp_digit = digits_in[slot*W +: W];
            exp_idx   = IW'(slot);
            exp_anode = off ? '1 : ~(N'(1) << slot);
            exp_fs    = (ecount > 0) && (ecount % (N * P) == 0);
            ecount++;
         end else begin
            exp_anode = '1;
            exp_fs    = 1'b0;
         end
         if (en6) begin
            slot       = pos6 % 6;
            exp_digit6 = digits6[slot*4 +: 4];
            exp_idx6   = 3'(slot);
            exp_anode6 = ~(6'(1) << slot);
            exp_fs6    = (pos6 > 0) && (pos6 % 6 == 0);
            pos6++;
         end else begin
            exp_anode6 = '1;
            exp_fs6    = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; en6 = 1'b0; digits_in = 16'h1234; blank_mask = '0; digits6 = '0;
`ifdef SCAN_BLINK_EN
      blink_mask = '0;
`endif
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; if (digit_out !== 4'h0) begin n_fail++; $display("FAIL reset digit_out: got %0h want 0", digit_out); end
         n_checks++; if (anode_n !== 4'hF) begin n_fail++; $display("FAIL reset anode_n: got %b want 1111", anode_n); end
         n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL reset digit_idx: got %0d want 0", digit_idx); end
         n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset frame_start: got %b want 0", frame_start); end
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_scan();
      int fs_seen = 0;
      int last_fs = 0;
      for (int i = 1; i <= 48; i++) begin
         tick();
         n_checks++; if (digit_out !== exp_digit) begin n_fail++; $display("FAIL scan digit_out cyc %0d: got %0h want %0h", i, digit_out, exp_digit); end
         n_checks++; if (anode_n !== exp_anode) begin n_fail++; $display("FAIL scan anode_n cyc %0d: got %b want %b", i, anode_n, exp_anode); end
         n_checks++; if (digit_idx !== exp_idx) begin n_fail++; $display("FAIL scan digit_idx cyc %0d: got %0d want %0d", i, digit_idx, exp_idx); end
         n_checks++; if (frame_start !== exp_fs) begin n_fail++; $display("FAIL scan frame_start cyc %0d: got %b want %b", i, frame_start, exp_fs); end
         if (frame_start === 1'b1) begin
            if (fs_seen > 0) begin
               n_checks++; if (i - last_fs != 12) begin n_fail++; $display("FAIL scan frame_period: got %0d want 12", i - last_fs); end
            end
            fs_seen++;
            last_fs = i;
         end
      end
      n_checks++; if (fs_seen != 3) begin n_fail++; $display("FAIL scan frame_count: got %0d want 3", fs_seen); end
   endtask

   task automatic test_blank();
      blank_mask = 4'b0100;
      for (int i = 0; i < 24; i++) begin
         tick();
         n_checks++; if (anode_n !== exp_anode) begin n_fail++; $display("FAIL blank anode_n: got %b want %b", anode_n, exp_anode); end
         n_checks++; if (digit_out !== exp_digit) begin n_fail++; $display("FAIL blank digit_out: got %0h want %0h", digit_out, exp_digit); end
         if (digit_idx === 2'd2) begin
            n_checks++; if (anode_n !== 4'hF || digit_out !== 4'h2) begin n_fail++; $display("FAIL blank slot2: got %b/%0h want 1111/2", anode_n, digit_out); end
         end
      end
      blank_mask = '0;
   endtask

   task automatic test_enable();
      logic [IW-1:0] prev = digit_idx;
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (digit_idx === 2'd1 && prev !== 2'd1) found = 1;
         prev = digit_idx;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL enable wait_idx1: got timeout want digit_idx 1"); end
      tick();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (anode_n !== 4'hF) begin n_fail++; $display("FAIL enable off anode_n: got %b want 1111", anode_n); end
         n_checks++; if (digit_idx !== 2'd1) begin n_fail++; $display("FAIL enable off digit_idx: got %0d want 1", digit_idx); end
         n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL enable off frame_start: got %b want 0", frame_start); end
      end
      en = 1'b1;
      tick();
      n_checks++; if (digit_idx !== 2'd1 || anode_n !== 4'b1101) begin n_fail++; $display("FAIL enable resume slot1: got %0d/%b want 1/1101", digit_idx, anode_n); end
      tick();
      n_checks++; if (digit_idx !== 2'd2 || anode_n !== 4'b1011) begin n_fail++; $display("FAIL enable advance slot2: got %0d/%b want 2/1011", digit_idx, anode_n); end
      for (int i = 0; i < 15; i++) begin
         tick();
         n_checks++; if (digit_idx !== exp_idx || anode_n !== exp_anode) begin n_fail++; $display("FAIL enable resume: got %0d/%b want %0d/%b", digit_idx, anode_n, exp_idx, exp_anode); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         tick();
         n_checks++; if (digit_out !== exp_digit) begin n_fail++; $display("FAIL random digit_out cyc %0d: got %0h want %0h", i, digit_out, exp_digit); end
         n_checks++; if (anode_n !== exp_anode) begin n_fail++; $display("FAIL random anode_n cyc %0d: got %b want %b", i, anode_n, exp_anode); end
         n_checks++; if (digit_idx !== exp_idx) begin n_fail++; $display("FAIL random digit_idx cyc %0d: got %0d want %0d", i, digit_idx, exp_idx); end
         n_checks++; if (frame_start !== exp_fs) begin n_fail++; $display("FAIL random frame_start cyc %0d: got %b want %b", i, frame_start, exp_fs); end
         digits_in  = 16'($urandom);
         blank_mask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : '0;
         en         = ($urandom_range(0, 9) != 0);
`ifdef SCAN_BLINK_EN
         blink_mask = 4'($urandom);
`endif
      end
      en = 1'b1; blank_mask = '0; digits_in = 16'h1234;
`ifdef SCAN_BLINK_EN
      blink_mask = '0;
`endif
   endtask

   task automatic test_async_reset();
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (digit_idx === 2'd3) found = 1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL areset wait_idx3: got timeout want digit_idx 3"); end
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (digit_out !== 4'h0) begin n_fail++; $display("FAIL areset digit_out: got %0h want 0", digit_out); end
      n_checks++; if (anode_n !== 4'hF) begin n_fail++; $display("FAIL areset anode_n: got %b want 1111", anode_n); end
      n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL areset digit_idx: got %0d want 0", digit_idx); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL areset frame_start: got %b want 0", frame_start); end
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         n_checks++; if (digit_idx !== exp_idx || anode_n !== exp_anode || digit_out !== exp_digit) begin n_fail++; $display("FAIL areset restart cyc %0d: got %0d/%b/%0h want %0d/%b/%0h", i, digit_idx, anode_n, digit_out, exp_idx, exp_anode, exp_digit); end
         n_checks++; if (frame_start !== exp_fs) begin n_fail++; $display("FAIL areset frame_start cyc %0d: got %b want %b", i, frame_start, exp_fs); end
         if (i < 13) begin
            n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL areset early_frame cyc %0d: got %b want 0", i, frame_start); end
         end
      end
   endtask

   task automatic test_six();
      en6 = 1'b1;
      digits6 = 24'($urandom);
      for (int i = 0; i < 30; i++) begin
         tick();
         n_checks++; if (digit_idx6 !== exp_idx6) begin n_fail++; $display("FAIL six digit_idx cyc %0d: got %0d want %0d", i, digit_idx6, exp_idx6); end
         n_checks++; if (anode_n6 !== exp_anode6) begin n_fail++; $display("FAIL six anode_n cyc %0d: got %b want %b", i, anode_n6, exp_anode6); end
         n_checks++; if (digit_out6 !== exp_digit6) begin n_fail++; $display("FAIL six digit_out cyc %0d: got %0h want %0h", i, digit_out6, exp_digit6); end
         n_checks++; if (frame_start6 !== exp_fs6) begin n_fail++; $display("FAIL six frame_start cyc %0d: got %b want %b", i, frame_start6, exp_fs6); end
         n_checks++; if (!(digit_idx6 < 3'd6) || $countones(~anode_n6) != 1) begin n_fail++; $display("FAIL six range: got idx %0d anode %b want idx<6 one-hot", digit_idx6, anode_n6); end
         digits6 = 24'($urandom);
      end
   endtask

`ifdef SCAN_BLINK_EN
   task automatic test_blink();
      int lit0 = 0;
      @(negedge clk) rst_n = 1'b0;
      model_reset();
      en = 1'b1; blank_mask = '0; digits_in = 16'h1234; blink_mask = 4'b0001;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 96; i++) begin
         tick();
         n_checks++; if (anode_n !== exp_anode) begin n_fail++; $display("FAIL blink anode_n cyc %0d: got %b want %b", i, anode_n, exp_anode); end
         n_checks++; if (digit_out !== exp_digit) begin n_fail++; $display("FAIL blink digit_out cyc %0d: got %0h want %0h", i, digit_out, exp_digit); end
         if (anode_n === 4'b1110) lit0++;
      end
      n_checks++; if (lit0 != 12) begin n_fail++; $display("FAIL blink lit_digit0: got %0d want 12", lit0); end
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_scan();
      test_blank();
      test_enable();
      test_random();
      test_async_reset();
      test_six();
`ifdef SCAN_BLINK_EN
      test_blink();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
